// File: rtl/inst_prefetch_queue_pkg.sv
// Shared constants and entry layout for the instruction prefetch queue.
// Default geometry; the top module may override DEPTH and WIDTH per instance.
package inst_prefetch_queue_pkg;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instruction;
  } entry_t;
endpackage

// File: rtl/inst_prefetch_queue_mem.sv
// Entry storage: synchronous write port, asynchronous read port, no reset.
module prefetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int DW    = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/inst_prefetch_queue.sv
// Fetch-to-decode FIFO with freeze/mem_freeze stalls and a flush that empties it.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = inst_prefetch_queue_pkg::DEPTH,
  parameter int WIDTH = inst_prefetch_queue_pkg::WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_pc,
  input  logic [WIDTH-1:0]           in_instruction,
  output logic                       in_ready,
  input  logic                       freeze,
  input  logic                       mem_freeze,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_pc,
  output logic [WIDTH-1:0]           out_instruction,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instruction;
  } q_entry_t;

  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;
  q_entry_t      w_wdata, w_rdata;

  assign in_ready  = (r_count < FULL);
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  // flush gates both sides so the offered entry is never written
  assign w_push = in_valid & in_ready & ~mem_freeze & ~flush;
  assign w_pop  = out_valid & ~freeze & ~mem_freeze & ~flush;

  assign w_wdata.pc          = in_pc;
  assign w_wdata.instruction = in_instruction;

  prefetch_queue_mem #(
    .DEPTH (DEPTH),
    .DW    (2*WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // an empty queue presents a NOP bubble rather than stale storage
  assign out_pc          = out_valid ? w_rdata.pc          : '0;
  assign out_instruction = out_valid ? w_rdata.instruction : '0;
endmodule
